// File: rtl/board_draw_scheduler.sv
// Redraw scheduler for the 4x4 sliding-puzzle board: keeps a pending-tile mask and
// hands one glyph job at a time (tile value + pixel origin) to the glyph drawer.
module board_draw_scheduler #(
    parameter int X_ORIGIN = 20,
    parameter int Y_ORIGIN = 0,
    parameter int PITCH    = 30,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] board,
    input  logic        redraw_all,
    input  logic        redraw_tile,
    input  logic [3:0]  redraw_idx,
    output logic        glyph_start,
    output logic [3:0]  glyph_value,
    output logic [7:0]  glyph_x,
    output logic [6:0]  glyph_y,
    input  logic        glyph_done,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic [15:0] mask_reg;
    logic [7:0]  tmo_cnt_reg;

    logic [15:0] req_bits;
    logic [15:0] mask_merged;
    logic [3:0]  first_idx;
    logic [7:0]  job_x;
    logic [6:0]  job_y;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_req
            assign req_bits[gi] = redraw_all | (redraw_tile & (redraw_idx == 4'(gi)));
        end
    endgenerate

    assign mask_merged = mask_reg | req_bits;

    // Lowest pending tile wins, so a frame is drawn in index order.
    always_comb begin
        first_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_reg[i]) begin
                first_idx = 4'(i);
            end
        end
    end

    assign job_x = 8'(X_ORIGIN + PITCH * int'(first_idx[1:0]));
    assign job_y = 7'(Y_ORIGIN + PITCH * int'(first_idx[3:2]));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            mask_reg    <= '0;
            tmo_cnt_reg <= '0;
            glyph_start <= 1'b0;
            glyph_value <= '0;
            glyph_x     <= '0;
            glyph_y     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            glyph_start <= 1'b0;
            frame_done  <= 1'b0;
            if (redraw_all) begin
                err <= 1'b0;
            end

            unique case (state_reg)
                IDLE: begin
                    mask_reg <= mask_merged;
                    if (mask_reg != '0) begin
                        state_reg <= ISSUE;
                        busy      <= 1'b1;
                    end else begin
                        busy <= (mask_merged != '0);
                    end
                end

                ISSUE: begin
                    // A same-cycle request for the issued tile keeps its bit set.
                    mask_reg    <= (mask_reg & ~(16'd1 << first_idx)) | req_bits;
                    glyph_start <= 1'b1;
                    glyph_value <= board[{first_idx, 2'b00} +: 4];
                    glyph_x     <= job_x;
                    glyph_y     <= job_y;
                    tmo_cnt_reg <= '0;
                    state_reg   <= WAIT;
                    busy        <= 1'b1;
                end

                WAIT: begin
                    mask_reg    <= mask_merged;
                    tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    busy        <= 1'b1;
                    if (glyph_done || (tmo_cnt_reg == TMO_LAST)) begin
                        if (!glyph_done) begin
                            err <= 1'b1;
                        end
                        if (mask_merged != '0) begin
                            state_reg <= ISSUE;
                        end else begin
                            state_reg  <= IDLE;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= (mask_reg != '0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_draw_scheduler.sv
// Directed bench for board_draw_scheduler: each task drives one scenario and
// checks the job stream against hand-computed tile values and origins.
module tb_board_draw_scheduler;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [63:0] board = '0;
    logic        redraw_all = 1'b0;
    logic        redraw_tile = 1'b0;
    logic [3:0]  redraw_idx = '0;
    logic        glyph_done = 1'b0;
    logic        glyph_start;
    logic [3:0]  glyph_value;
    logic [7:0]  glyph_x;
    logic [6:0]  glyph_y;
    logic        busy;
    logic        frame_done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    int start_cnt = 0;
    int frame_cnt = 0;

    always #5 clk = ~clk;

    board_draw_scheduler dut (
        .clk         (clk),
        .resetn      (resetn),
        .board       (board),
        .redraw_all  (redraw_all),
        .redraw_tile (redraw_tile),
        .redraw_idx  (redraw_idx),
        .glyph_start (glyph_start),
        .glyph_value (glyph_value),
        .glyph_x     (glyph_x),
        .glyph_y     (glyph_y),
        .glyph_done  (glyph_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .err         (err)
    );

    always @(negedge clk) begin
        if (glyph_start === 1'b1) begin
            start_cnt++;
            $display("job: value=%0d x=%0d y=%0d", glyph_value, glyph_x, glyph_y);
        end
        if (frame_done === 1'b1) begin
            frame_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req_tile(input int idx);
        redraw_tile = 1'b1;
        redraw_idx  = 4'(idx);
        @(negedge clk);
        redraw_tile = 1'b0;
    endtask

    task automatic pulse_done();
        glyph_done = 1'b1;
        @(negedge clk);
        glyph_done = 1'b0;
    endtask

    // Returns the number of negedges until glyph_start is seen, 0 on expiry.
    task automatic wait_start(input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (glyph_start === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        int base;
        #3 resetn = 1'b0;
        #1;
        vectors++;
        if ({glyph_start, glyph_value, glyph_x, glyph_y, busy, frame_done, err} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_init: got %h expected 000000",
                     {glyph_start, glyph_value, glyph_x, glyph_y, busy, frame_done, err});
        end
        @(negedge clk);
        resetn = 1'b1;
        tick(2);
        req_tile(3);
        wait_start(10, n);
        vectors++;
        if (n == 0 || glyph_x !== 8'd110) begin
            miscompares++;
            $display("FAIL reset_setup_job: got n=%0d x=%0d expected start with x=110", n, glyph_x);
        end
        req_tile(4); req_tile(5); req_tile(6); req_tile(7);
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if ({glyph_start, glyph_value, glyph_x, glyph_y, busy, frame_done, err} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_async_midwait: got %h expected 000000",
                     {glyph_start, glyph_value, glyph_x, glyph_y, busy, frame_done, err});
        end
        @(negedge clk);
        resetn = 1'b1;
        base = start_cnt;
        tick(40);
        vectors++;
        if (start_cnt != base || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mask_cleared: got starts=%0d busy=%b expected starts=0 busy=0",
                     start_cnt - base, busy);
        end
    endtask

    task automatic test_single_tile();
        int n;
        int base;
        board[23:20] = 4'd9;
        base = start_cnt;
        pulse_done();
        tick(4);
        vectors++;
        if (start_cnt != base || busy !== 1'b0 || frame_cnt != 0) begin
            miscompares++;
            $display("FAIL idle_done_ignored: got starts=%0d busy=%b frames=%0d expected 0 0 0",
                     start_cnt - base, busy, frame_cnt);
        end
        req_tile(5);
        wait_start(20, n);
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL single_latency: got %0d expected 2", n);
        end
        vectors++;
        if (glyph_value !== 4'd9 || glyph_x !== 8'd50 || glyph_y !== 7'd30 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_job: got value=%0d x=%0d y=%0d busy=%b expected 9 50 30 1",
                     glyph_value, glyph_x, glyph_y, busy);
        end
        pulse_done();
        vectors++;
        if (glyph_start !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_finish: got start=%b frame_done=%b busy=%b expected 0 1 0",
                     glyph_start, frame_done, busy);
        end
        tick(5);
        vectors++;
        if (frame_done !== 1'b0 || start_cnt != base + 1 || frame_cnt != 1) begin
            miscompares++;
            $display("FAIL single_counts: got frame_done=%b starts=%0d frames=%0d expected 0 1 1",
                     frame_done, start_cnt - base, frame_cnt);
        end
    endtask

    task automatic test_full_frame();
        int n;
        int base_f;
        logic [7:0] ex;
        logic [6:0] ey;
        for (int i = 0; i < 16; i++) begin
            board[4*i +: 4] = 4'(i);
        end
        base_f = frame_cnt;
        redraw_all = 1'b1;
        @(negedge clk);
        redraw_all = 1'b0;
        for (int j = 0; j < 16; j++) begin
            wait_start(20, n);
            ex = 8'(20 + 30 * (j % 4));
            ey = 7'(30 * (j / 4));
            vectors++;
            if (n == 0 || glyph_value !== 4'(j) || glyph_x !== ex || glyph_y !== ey) begin
                miscompares++;
                $display("FAIL frame_job_%0d: got n=%0d value=%0d x=%0d y=%0d expected value=%0d x=%0d y=%0d",
                         j, n, glyph_value, glyph_x, glyph_y, j, ex, ey);
            end
            if (j == 15) begin
                vectors++;
                if (frame_cnt != base_f) begin
                    miscompares++;
                    $display("FAIL frame_early_done: got %0d frame pulses expected 0", frame_cnt - base_f);
                end
            end
            tick(9);
            pulse_done();
        end
        vectors++;
        if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_done_pulse: got %b expected 1", frame_done);
        end
        tick(3);
        vectors++;
        if (frame_cnt != base_f + 1 || busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_end: got frames=%0d busy=%b err=%b expected 1 0 0",
                     frame_cnt - base_f, busy, err);
        end
    endtask

    task automatic test_inflight_rerequest();
        int n;
        int base_f;
        board[7:4]   = 4'd6;
        board[15:12] = 4'd11;
        base_f = frame_cnt;
        req_tile(3);
        wait_start(20, n);
        vectors++;
        if (n == 0 || glyph_value !== 4'd11) begin
            miscompares++;
            $display("FAIL inflight_first: got n=%0d value=%0d expected value=11", n, glyph_value);
        end
        req_tile(3);
        req_tile(1);
        pulse_done();
        wait_start(10, n);
        vectors++;
        if (n == 0 || glyph_value !== 4'd6 || glyph_x !== 8'd50 || glyph_y !== 7'd0) begin
            miscompares++;
            $display("FAIL inflight_tile1: got n=%0d value=%0d x=%0d y=%0d expected 6 50 0",
                     n, glyph_value, glyph_x, glyph_y);
        end
        pulse_done();
        wait_start(10, n);
        vectors++;
        if (n == 0 || glyph_value !== 4'd11 || glyph_x !== 8'd110 || glyph_y !== 7'd0) begin
            miscompares++;
            $display("FAIL inflight_tile3: got n=%0d value=%0d x=%0d y=%0d expected 11 110 0",
                     n, glyph_value, glyph_x, glyph_y);
        end
        pulse_done();
        tick(3);
        vectors++;
        if (frame_cnt != base_f + 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL inflight_frames: got frames=%0d busy=%b expected 1 0", frame_cnt - base_f, busy);
        end
    endtask

    task automatic test_board_change();
        int n;
        board[11:8] = 4'd4;
        req_tile(2);
        wait_start(20, n);
        vectors++;
        if (n == 0 || glyph_value !== 4'd4 || glyph_x !== 8'd80) begin
            miscompares++;
            $display("FAIL boardchg_start: got n=%0d value=%0d x=%0d expected 4 80", n, glyph_value, glyph_x);
        end
        board[11:8] = 4'd7;
        tick(5);
        vectors++;
        if (glyph_value !== 4'd4) begin
            miscompares++;
            $display("FAIL boardchg_hold: got %0d expected 4", glyph_value);
        end
        pulse_done();
        tick(2);
        req_tile(2);
        wait_start(20, n);
        vectors++;
        if (n == 0 || glyph_value !== 4'd7) begin
            miscompares++;
            $display("FAIL boardchg_new: got n=%0d value=%0d expected 7", n, glyph_value);
        end
        pulse_done();
        tick(3);
    endtask

    task automatic test_back_to_back();
        int n;
        req_tile(0);
        req_tile(1);
        wait_start(20, n);
        vectors++;
        if (n == 0 || glyph_x !== 8'd20 || glyph_y !== 7'd0) begin
            miscompares++;
            $display("FAIL b2b_first: got n=%0d x=%0d y=%0d expected 20 0", n, glyph_x, glyph_y);
        end
        pulse_done();
        wait_start(10, n);
        vectors++;
        if (n !== 1 || glyph_x !== 8'd50) begin
            miscompares++;
            $display("FAIL b2b_spacing: got n=%0d x=%0d expected n=1 x=50", n, glyph_x);
        end
        pulse_done();
        tick(3);
    endtask

    task automatic test_timeout();
        int n;
        board[35:32] = 4'd5;
        board[39:36] = 4'd3;
        req_tile(8);
        req_tile(9);
        wait_start(20, n);
        vectors++;
        if (n == 0 || glyph_value !== 4'd5 || glyph_x !== 8'd20 || glyph_y !== 7'd60) begin
            miscompares++;
            $display("FAIL tmo_first: got n=%0d value=%0d x=%0d y=%0d expected 5 20 60",
                     n, glyph_value, glyph_x, glyph_y);
        end
        wait_start(300, n);
        vectors++;
        if (n !== 256) begin
            miscompares++;
            $display("FAIL tmo_latency: got %0d expected 256", n);
        end
        vectors++;
        if (err !== 1'b1 || glyph_value !== 4'd3 || glyph_x !== 8'd50 || glyph_y !== 7'd60) begin
            miscompares++;
            $display("FAIL tmo_next_job: got err=%b value=%0d x=%0d y=%0d expected 1 3 50 60",
                     err, glyph_value, glyph_x, glyph_y);
        end
        pulse_done();
        tick(3);
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_sticky: got err=%b busy=%b expected 1 0", err, busy);
        end
        redraw_all = 1'b1;
        @(negedge clk);
        redraw_all = 1'b0;
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_clear: got err=%b busy=%b expected 0 1", err, busy);
        end
        for (int j = 0; j < 16; j++) begin
            wait_start(20, n);
            pulse_done();
        end
        tick(3);
        vectors++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_drain: got busy=%b err=%b expected 0 0", busy, err);
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_full_frame();
        test_inflight_rerequest();
        test_board_change();
        test_back_to_back();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/board_draw_scheduler.md
Name: board_draw_scheduler

Overview:
Sequences redraws of the 4x4 sliding-puzzle board. It keeps a 16-bit pending-redraw mask and issues one glyph-draw job at a time to the number-glyph drawer: the tile value plus the tile's pixel origin. It waits for the drawer's completion before issuing the next job. It sits between the game-logic FSM, which raises redraw requests, and the glyph drawer / VGA plot path.

Parameters:
X_ORIGIN, 20, pixel x of tile 0 top-left corner
Y_ORIGIN, 0, pixel y of tile 0 top-left corner
PITCH, 30, tile spacing in pixels (both axes)
TIMEOUT, 255, max cycles to wait for glyph_done before abort (8-bit counter)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
board  in  64  tile values; tile i at [4i+3:4i], i = row*4+col, value 0 = blank
redraw_all  in  1  pulse; mark all 16 tiles pending
redraw_tile  in  1  pulse; mark tile redraw_idx pending
redraw_idx  in  4  tile index for redraw_tile
glyph_start  out  1  one-cycle job strobe to drawer
glyph_value  out  4  tile value for current job
glyph_x  out  8  job origin x
glyph_y  out  7  job origin y
glyph_done  in  1  drawer completion pulse
busy  out  1  high whenever state != IDLE or mask != 0
frame_done  out  1  one-cycle pulse when mask drains to empty
err  out  1  sticky timeout flag

Behaviour:
- Reset (async, resetn=0): state IDLE, mask=0, all outputs 0, timeout counter 0. Takes effect immediately, including mid-job. The drawer is not notified.
- Requests: on each clk edge, mask |= (redraw_all ? 16'hFFFF : 0) | (redraw_tile ? 1<<redraw_idx : 0).
  - Both requests asserted together: union of the two (effectively all).
  - Requests are accepted in every state.
  - A request for a tile already in flight re-sets its bit, so that tile is drawn again later.
- States:
  - IDLE: if mask != 0, go to ISSUE.
  - ISSUE: select lowest set bit k (priority encoder). Register glyph_value = board[4k+3:4k], glyph_x = X_ORIGIN + k[1:0]*PITCH, glyph_y = Y_ORIGIN + k[3:2]*PITCH, truncated to 8/7 bits. Pulse glyph_start for exactly one cycle, clear mask bit k (a request for k in the same cycle wins and keeps it set), reset the timeout counter, go to WAIT.
  - WAIT: increment the timeout counter each cycle.
    - On glyph_done: if mask != 0 go to ISSUE; else go to IDLE and pulse frame_done.
    - If the counter reaches TIMEOUT with no glyph_done: set err, treat as done (same transitions).
- glyph_done outside WAIT is ignored.
- glyph_value/x/y are captured from board at the job's start cycle. They hold stable until the next glyph_start; later board changes do not affect the job in flight.
- Latency: a request sampled at edge E with the scheduler idle produces glyph_start high in the cycle following edge E+2 (request -> IDLE sees mask -> ISSUE). With glyph_done already pending at the WAIT exit edge, the next glyph_start follows 1 cycle later (WAIT -> ISSUE). Minimum job spacing is 2 cycles.
- Blank tiles (value 0) are issued like any other tile; the drawer paints background.
- err clears on redraw_all or reset only.
- frame_done pulses once per drain to empty, not once per request.

Test Plan:
- Reset: hold resetn=0 mid-WAIT with mask=16'h00F0 -> all outputs 0 and mask 0 asynchronously; after release, no glyph_start without a new request.
- Single tile: board tile 5 = 9, redraw_tile idx=5 -> exactly one glyph_start, value 9, x=50, y=30. After glyph_done, frame_done pulses once and busy drops.
- Full frame: redraw_all, drawer returns done 10 cycles after each start -> 16 starts in index order 0..15 with x in {20,50,80,110}, y in {0,30,60,90}; exactly one frame_done, after the 16th done.
- In-flight re-request: during WAIT for tile 3, pulse redraw_tile idx=3 and idx=1 -> next jobs are tile 1 then tile 3, then frame_done.
- Board change mid-job: change tile 2 from 4 to 7 after its glyph_start -> glyph_value stays 4 until the next start.
- Timeout: drawer never asserts done -> after 255 WAIT cycles err=1 and the next pending tile is issued. A following redraw_all clears err.
